uart_loader: RTL

Boot-time program loader sitting directly upstream of the CPU core. It receives a serial byte stream on the UART RX pin and assembles little-endian 32-bit words. It drives the core's `uart_data` / `uart_addr` / `uart_done` inputs, which write the image into unified memory through port B while the core is held in reset. When `uart_done` rises, the core is released.

---
 rtl/uart_loader.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/uart_loader.sv
// Boot-time program loader: deserializes UART bytes, assembles little-endian
// 32-bit words and streams them into memory after a word-count header.
module uart_loader #(
    parameter int          CLKS_PER_BIT = 100,
    parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
    parameter int          MAX_WORDS    = 16384
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx,
    input  logic        skip,
    output logic [31:0] uart_data,
    output logic [31:0] uart_addr,
    output logic        uart_we,
    output logic        uart_done,
    output logic        frame_err
);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [31:0]      MAX_W   = 32'(MAX_WORDS);

    typedef enum logic [2:0] {
        RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT_HIGH
    } rx_state_t;

    typedef enum logic [1:0] {
        LD_WAIT_HDR, LD_LOAD, LD_DONE
    } ld_state_t;

    rx_state_t        rx_state_q;
    ld_state_t        ld_state_q;
    logic             rx_meta_q, rx_sync_q;
    logic [CNT_W-1:0] cnt_q;
    logic [2:0]       bit_q;
    logic [7:0]       shift_q;
    logic             byte_valid_q;
    logic [1:0]       bidx_q;
    logic [23:0]      asm_q;
    logic [31:0]      n_q, idx_q;
    logic [31:0]      word_s, n_s;
    logic             word_done_s;

    // Synchronizer and bit-level receive state machine.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta_q    <= 1'b1;
            rx_sync_q    <= 1'b1;
            rx_state_q   <= RX_IDLE;
            cnt_q        <= '0;
            bit_q        <= 3'd0;
            shift_q      <= 8'd0;
            byte_valid_q <= 1'b0;
            frame_err    <= 1'b0;
        end else begin
            rx_meta_q    <= rx;
            rx_sync_q    <= rx_meta_q;
            byte_valid_q <= 1'b0;
            case (rx_state_q)
                RX_IDLE: begin
                    cnt_q <= '0;
                    if (!rx_sync_q) rx_state_q <= RX_START;
                end
                RX_START: begin
                    if (cnt_q == HALF_M1) begin
                        cnt_q <= '0;
                        bit_q <= 3'd0;
                        // A high line at mid-start is a glitch, not a frame.
                        rx_state_q <= rx_sync_q ? RX_IDLE : RX_DATA;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                RX_DATA: begin
                    if (cnt_q == FULL_M1) begin
                        cnt_q   <= '0;
                        shift_q <= {rx_sync_q, shift_q[7:1]};
                        if (bit_q == 3'd7) rx_state_q <= RX_STOP;
                        else               bit_q      <= bit_q + 3'd1;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                RX_STOP: begin
                    if (cnt_q == FULL_M1) begin
                        cnt_q <= '0;
                        if (rx_sync_q) begin
                            byte_valid_q <= 1'b1;
                            rx_state_q   <= RX_IDLE;
                        end else begin
                            frame_err  <= 1'b1;
                            rx_state_q <= RX_WAIT_HIGH;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                RX_WAIT_HIGH: begin
                    if (rx_sync_q) rx_state_q <= RX_IDLE;
                end
                default: rx_state_q <= RX_IDLE;
            endcase
        end
    end

    // Byte-lane placement of the first three bytes of each word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bidx_q <= 2'd0;
            asm_q  <= 24'd0;
        end else if (byte_valid_q) begin
            bidx_q <= bidx_q + 2'd1;
            case (bidx_q)
                2'd0:    asm_q[7:0]   <= shift_q;
                2'd1:    asm_q[15:8]  <= shift_q;
                2'd2:    asm_q[23:16] <= shift_q;
                default: asm_q        <= asm_q;
            endcase
        end
    end

    // Completed word and clamped header count.
    always_comb begin
        word_s      = {shift_q, asm_q};
        word_done_s = byte_valid_q && (bidx_q == 2'd3);
        if (word_s > MAX_W) n_s = MAX_W;
        else                n_s = word_s;
    end

    // Load sequencer with registered memory-write outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ld_state_q <= LD_WAIT_HDR;
            n_q        <= 32'd0;
            idx_q      <= 32'd0;
            uart_data  <= 32'd0;
            uart_addr  <= BASE_ADDR;
            uart_we    <= 1'b0;
            uart_done  <= 1'b0;
        end else begin
            uart_we <= 1'b0;
            case (ld_state_q)
                LD_WAIT_HDR: begin
                    if (word_done_s) begin
                        n_q   <= n_s;
                        idx_q <= 32'd0;
                        if (n_s == 32'd0) begin
                            ld_state_q <= LD_DONE;
                            uart_done  <= 1'b1;
                        end else begin
                            ld_state_q <= LD_LOAD;
                        end
                    end else if (skip && (bidx_q == 2'd0) && !byte_valid_q) begin
                        // An arriving byte takes priority over skip.
                        ld_state_q <= LD_DONE;
                        uart_done  <= 1'b1;
                    end else begin
                        ld_state_q <= LD_WAIT_HDR;
                    end
                end
                LD_LOAD: begin
                    if (word_done_s) begin
                        uart_data <= word_s;
                        uart_addr <= BASE_ADDR + {idx_q[29:0], 2'b00};
                        uart_we   <= 1'b1;
                        idx_q     <= idx_q + 32'd1;
                        if (idx_q == n_q - 32'd1) ld_state_q <= LD_DONE;
                    end
                end
                LD_DONE: uart_done <= 1'b1;
                default: ld_state_q <= LD_WAIT_HDR;
            endcase
        end
    end
endmodule
